// File: rtl/ram_stream_reader.sv
// Block reader for an altsyncram read port: issues consecutive reads, tracks the
// fixed read latency and returns the words as a valid/ready stream via a credit FIFO.

module ram_stream_reader_chk #(
   parameter int CW         = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic          clock0,
   input logic          sclr,
   input logic          push,
   input logic [CW-1:0] fifo_cnt
);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   a_no_overflow: assert property (@(posedge clock0) disable iff (sclr)
      !(push && (fifo_cnt == FULL_CNT)));
   a_cnt_range: assert property (@(posedge clock0) disable iff (sclr)
      fifo_cnt <= FULL_CNT);
endmodule

module ram_stream_reader #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock0,
   input  logic                  sclr,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_adr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_rden,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [ADDR_WIDTH-1:0] ADR_ONE  = ADDR_WIDTH'(1'b1);
   localparam logic [ADDR_WIDTH-1:0] ADR_ZERO = ADDR_WIDTH'(1'b0);
   localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1'b1);
   localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
   localparam logic [CW1-1:0]        DEPTH_W  = CW1'(FIFO_DEPTH);
   localparam logic [PW-1:0]         PTR_ONE  = PW'(1'b1);
   localparam logic [PW-1:0]         PTR_ZERO = {PW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_r, state_nx_s;
   logic [ADDR_WIDTH-1:0]   adr_cnt_r, adr_cnt_nx_s;
   logic [ADDR_WIDTH:0]     remain_r, remain_nx_s;
   logic [ADDR_WIDTH-1:0]   ram_adr_r, issue_adr_s;
   logic                    rden_r, issue_nx_s;
   logic                    last_issue_r, last_nx_s;
   logic                    zero_len_r, zero_nx_s;
   logic                    done_r, done_nx_s;
   logic [READ_LATENCY-1:0] vld_pipe_r, lst_pipe_r;
   logic [CW-1:0]           inflight_r, inflight_nx_s;
   logic [CW-1:0]           fifo_cnt_r, fifo_cnt_nx_s;
   logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
   logic [DATA_WIDTH-1:0]   dat_mem_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   lst_mem_r;
   logic                    push_s, pop_s, credit_ok_s;

   // Credit bookkeeping: the issue for the next cycle is decided from next-cycle counts
   always_comb begin
      push_s        = vld_pipe_r[READ_LATENCY-1];
      pop_s         = (fifo_cnt_r != CNT_ZERO) && m_ready;
      inflight_nx_s = inflight_r + CW'(rden_r) - CW'(push_s);
      fifo_cnt_nx_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
      credit_ok_s   = ({1'b0, inflight_nx_s} + {1'b0, fifo_cnt_nx_s}) < DEPTH_W;
   end

   // Next-state and next-issue decode
   always_comb begin
      state_nx_s   = state_r;
      issue_nx_s   = 1'b0;
      issue_adr_s  = adr_cnt_r;
      adr_cnt_nx_s = adr_cnt_r;
      remain_nx_s  = remain_r;
      last_nx_s    = 1'b0;
      zero_nx_s    = zero_len_r;
      done_nx_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (length != LEN_ZERO) begin
                  state_nx_s   = ST_RUN;
                  issue_nx_s   = 1'b1;
                  issue_adr_s  = base_adr;
                  adr_cnt_nx_s = base_adr + ADR_ONE;
                  remain_nx_s  = length - LEN_ONE;
                  last_nx_s    = (length == LEN_ONE);
                  zero_nx_s    = 1'b0;
               end else begin
                  state_nx_s  = ST_DRAIN;
                  remain_nx_s = LEN_ZERO;
                  zero_nx_s   = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (rden_r && last_issue_r) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_RUN;
            end
            if ((remain_r != LEN_ZERO) && credit_ok_s) begin
               issue_nx_s   = 1'b1;
               adr_cnt_nx_s = adr_cnt_r + ADR_ONE;
               remain_nx_s  = remain_r - LEN_ONE;
               last_nx_s    = (remain_r == LEN_ONE);
            end else begin
               issue_nx_s = 1'b0;
            end
         end
         ST_DRAIN: begin
            // A zero-length transfer completes one cycle after it was accepted
            if (zero_len_r || (pop_s && m_last)) begin
               state_nx_s = ST_IDLE;
               done_nx_s  = 1'b1;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock0) begin
      if (sclr) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Issue registers: address counter, remaining count and the registered RAM request
   always_ff @(posedge clock0) begin
      if (sclr) begin
         adr_cnt_r    <= ADR_ZERO;
         remain_r     <= LEN_ZERO;
         ram_adr_r    <= ADR_ZERO;
         rden_r       <= 1'b0;
         last_issue_r <= 1'b0;
         zero_len_r   <= 1'b0;
         done_r       <= 1'b0;
         inflight_r   <= CNT_ZERO;
      end else begin
         adr_cnt_r    <= adr_cnt_nx_s;
         remain_r     <= remain_nx_s;
         rden_r       <= issue_nx_s;
         last_issue_r <= last_nx_s;
         zero_len_r   <= zero_nx_s;
         done_r       <= done_nx_s;
         inflight_r   <= inflight_nx_s;
         if (issue_nx_s) begin
            ram_adr_r <= issue_adr_s;
         end
      end
   end

   // Latency pipeline: one valid/last tag per issued read, exits as ram_q is valid
   always_ff @(posedge clock0) begin
      if (sclr) begin
         vld_pipe_r <= {READ_LATENCY{1'b0}};
         lst_pipe_r <= {READ_LATENCY{1'b0}};
      end else begin
         vld_pipe_r[0] <= rden_r;
         lst_pipe_r[0] <= rden_r && last_issue_r;
         for (int k = 1; k < READ_LATENCY; k++) begin
            vld_pipe_r[k] <= vld_pipe_r[k-1];
            lst_pipe_r[k] <= lst_pipe_r[k-1];
         end
      end
   end

   // Output FIFO; storage is cleared on reset so the head reads as zero
   always_ff @(posedge clock0) begin
      if (sclr) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         fifo_cnt_r <= CNT_ZERO;
         lst_mem_r  <= {FIFO_DEPTH{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            dat_mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (push_s) begin
            dat_mem_r[wr_ptr_r] <= ram_q;
            lst_mem_r[wr_ptr_r] <= lst_pipe_r[READ_LATENCY-1];
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         fifo_cnt_r <= fifo_cnt_nx_s;
      end
   end

   assign busy        = (state_r != ST_IDLE);
   assign done        = done_r;
   assign ram_rden    = rden_r;
   assign ram_address = ram_adr_r;
   assign m_valid     = (fifo_cnt_r != CNT_ZERO);
   assign m_data      = dat_mem_r[rd_ptr_r];
   assign m_last      = lst_mem_r[rd_ptr_r];

   ram_stream_reader_chk #(
      .CW         (CW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_chk (
      .clock0   (clock0),
      .sclr     (sclr),
      .push     (push_s),
      .fifo_cnt (fifo_cnt_r)
   );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench: two readers (read latency 1 and 2) share one stimulus stream,
// each with its own RAM model and expectation queues checked by a monitor.

module tb_ram_stream_reader;
   localparam int DW       = 8;
   localparam int AW       = 10;
   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 2000;

   logic          clock0 = 1'b0;
   logic          sclr, start, m_ready;
   logic [AW-1:0] base_adr;
   logic [AW:0]   length;
   logic [1:0]    busy_v, done_v, rden_v, mv_v, ml_v;
   logic [AW-1:0] adr_v [2];
   logic [DW-1:0] md_v [2];
   logic [DW-1:0] ram_mem [1 << AW];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit chk_reset = 1'b0;
   bit chk_stall = 1'b0;
   bit chk_empty = 1'b0;
   int stall_left = 0;
   int adr_q  [2][$];
   int beat_q [2][$];
   int bcyc_q [2][$];
   int done_q [2][$];
   bit            hold_v [2];
   logic [DW-1:0] hold_d [2];

   always #5 clock0 = ~clock0;

   always @(posedge clock0) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_lat
      logic [DW-1:0] rd1, rd2, q;
      always @(posedge clock0) begin
         if (rden_v[g]) rd1 <= ram_mem[adr_v[g]];
         rd2 <= rd1;
      end
      assign q = (g == 0) ? rd1 : rd2;
      ram_stream_reader #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(g + 1), .FIFO_DEPTH(DEPTH)
      ) u_dut (
         .clock0(clock0), .sclr(sclr), .start(start), .base_adr(base_adr),
         .length(length), .busy(busy_v[g]), .done(done_v[g]),
         .ram_address(adr_v[g]), .ram_rden(rden_v[g]), .ram_q(q),
         .m_valid(mv_v[g]), .m_ready(m_ready), .m_data(md_v[g]), .m_last(ml_v[g])
      );
   end

   task automatic cmp(input string name, input int g, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (latency %0d) cycle %0d: got 0x%0h, want 0x%0h",
                  name, g + 1, cyc, act, exp);
      end
   endtask

   always @(negedge clock0) begin : mon
      int e;
      for (int g = 0; g < 2; g++) begin
         if (chk_reset) begin
            cmp("rst_busy", g, 32'(busy_v[g]), 32'd0);
            cmp("rst_done", g, 32'(done_v[g]), 32'd0);
            cmp("rst_rden", g, 32'(rden_v[g]), 32'd0);
            cmp("rst_address", g, 32'(adr_v[g]), 32'd0);
            cmp("rst_m_valid", g, 32'(mv_v[g]), 32'd0);
            cmp("rst_m_data", g, 32'(md_v[g]), 32'd0);
            cmp("rst_m_last", g, 32'(ml_v[g]), 32'd0);
         end
         if (chk_stall) begin
            cmp("stall_reads_pending", g, 32'(adr_q[g].size()), 32'(stall_left));
            cmp("stall_rden", g, 32'(rden_v[g]), 32'd0);
         end
         if (rden_v[g]) begin
            e = (adr_q[g].size() != 0) ? adr_q[g].pop_front() : -1;
            cmp("ram_address", g, 32'(adr_v[g]), 32'(e));
         end
         if (mv_v[g] && m_ready) begin
            if (beat_q[g].size() != 0) begin
               e = beat_q[g].pop_front();
               cmp("beat", g, 32'({ml_v[g], md_v[g]}), 32'(e));
               e = bcyc_q[g].pop_front();
               if (e >= 0) cmp("beat_cycle", g, 32'(cyc), 32'(e));
            end else begin
               cmp("stray_beat", g, 32'({ml_v[g], md_v[g]}), 32'hFFFF_FFFF);
            end
         end
         if (mv_v[g] && !m_ready) begin
            if (hold_v[g]) cmp("m_data_stable", g, 32'(md_v[g]), 32'(hold_d[g]));
            hold_v[g] = 1'b1;
            hold_d[g] = md_v[g];
         end else begin
            hold_v[g] = 1'b0;
         end
         if (done_v[g]) begin
            e = (done_q[g].size() != 0) ? done_q[g].pop_front() : -2;
            if (e != -1) cmp("done_cycle", g, 32'(cyc), 32'(e));
            cmp("busy_at_done", g, 32'(busy_v[g]), 32'd0);
         end
         if (chk_empty) begin
            cmp("reads_outstanding", g, 32'(adr_q[g].size()), 32'd0);
            cmp("beats_outstanding", g, 32'(beat_q[g].size()), 32'd0);
            cmp("done_outstanding", g, 32'(done_q[g].size()), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clock0);
      #1;
   endtask

   // Drive a one-cycle start; when timed, beats and done carry exact expected cycles
   task automatic xfer(input int b, input int n, input bit timed);
      int t0;
      int a;
      tick();
      t0       = cyc;
      start    = 1'b1;
      base_adr = AW'(b);
      length   = (AW + 1)'(n);
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < n; i++) begin
            a = (b + i) % (1 << AW);
            adr_q[g].push_back(a);
            beat_q[g].push_back(((i == n - 1) ? 256 : 0) + ((a + 16) % 256));
            bcyc_q[g].push_back(timed ? t0 + 2 + (g + 1) + i : -1);
         end
         if (!timed) done_q[g].push_back(-1);
         else if (n == 0) done_q[g].push_back(t0 + 2);
         else done_q[g].push_back(t0 + 2 + (g + 1) + n);
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (((busy_v != 2'b00) || (mv_v != 2'b00)) && (k < MAX_WAIT));
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'(i + 16);
      sclr     = 1'b1;
      start    = 1'b0;
      m_ready  = 1'b1;
      base_adr = {AW{1'b0}};
      length   = {(AW + 1){1'b0}};
      repeat (3) tick();
      chk_reset = 1'b1;
      tick();
      chk_reset = 1'b0;
      sclr      = 1'b0;

      // Basic block with a start pulse during RUN that must be ignored
      xfer(4, 5, 1'b1);
      tick();
      start    = 1'b1;
      base_adr = AW'(32'h100);
      length   = (AW + 1)'(3);
      tick();
      start = 1'b0;
      wait_idle();

      xfer(1022, 4, 1'b1);
      wait_idle();
      xfer(0, 0, 1'b1);
      wait_idle();

      // Backpressure: full stall first, then random ready
      m_ready = 1'b0;
      xfer(32'h20, 32, 1'b0);
      repeat (12) tick();
      stall_left = 28;
      chk_stall  = 1'b1;
      tick();
      chk_stall = 1'b0;
      for (int k = 0; (k < MAX_WAIT) && (busy_v != 2'b00); k++) begin
         m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      m_ready = 1'b1;
      wait_idle();

      // Reset with two reads in flight; nothing of that transfer may surface afterwards
      xfer(32'h40, 8, 1'b0);
      tick();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      for (int g = 0; g < 2; g++) begin
         adr_q[g].delete();
         beat_q[g].delete();
         bcyc_q[g].delete();
         done_q[g].delete();
      end
      chk_reset = 1'b1;
      tick();
      chk_reset = 1'b0;
      repeat (8) tick();

      xfer(32'h50, 3, 1'b1);
      wait_idle();
      tick();

      chk_empty = 1'b1;
      tick();
      chk_empty = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
